sys_debug_scanner: RTL and testbench

Board-side debug controller that drives the system's observation/control pins (output select, PC load, PC value) and reads back the 27-bit LED word. On a start pulse it optionally forces a PC load, then steps the output select through every view and captures each LED word into an internal snapshot buffer. It then streams the snapshot out over a valid/ready word interface. It sits between the core's SYS_* pins and a host or monitor, such as a UART bridge or a logic-analyser FIFO.

---
 rtl/sys_debug_scanner.sv | 140 ++++++++++++++
 tb/tb_sys_debug_scanner.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_debug_scanner.sv
// Debug scanner: optional PC load, steps SYS output_sel through every view, snapshots the
// LED word per view and streams the snapshot out over valid/ready. Optional: DBG_FREEZE_EN.
module sys_debug_scanner #(
    parameter int NUM_SEL    = 8,
    parameter int SETTLE_CYC = 2,
    parameter int LED_W      = 27
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             DBG_start,
    input  logic             DBG_load_req,
    input  logic [7:0]       DBG_pc_val,
    output logic [7:0]       DBG_output_sel,
    output logic             DBG_load,
    output logic [7:0]       DBG_pc_val_out,
    input  logic [LED_W-1:0] DBG_leds_in,
    output logic             DBG_busy,
    output logic             DBG_word_valid,
    input  logic             DBG_word_ready,
    output logic [2:0]       DBG_word_sel,
    output logic [LED_W-1:0] DBG_word_data,
    output logic             DBG_done
);

`ifdef DBG_FREEZE_EN
    typedef enum logic [2:0] {IDLE, LOAD, PREP, CAPTURE, DRAIN} state_t;
    localparam state_t SCAN_ENTRY = PREP;
`else
    typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, DRAIN} state_t;
    localparam state_t SCAN_ENTRY = CAPTURE;
`endif

    localparam int             SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [2:0]     SEL_LAST    = 3'(NUM_SEL - 1);
    localparam logic [3:0]     WORD_END    = 4'(NUM_SEL);

    state_t            state_q, state_d;
    logic [2:0]        sel_q;
    logic [SW-1:0]     settle_q;
    logic [3:0]        idx_q;
    logic [7:0]        pc_q;
    logic [LED_W-1:0]  snap_q [NUM_SEL];
    logic              settle_done;
`ifdef DBG_FREEZE_EN
    logic [7:0]        frozen_q;
`endif

    assign settle_done = (settle_q == SETTLE_LAST);
    assign DBG_busy    = (state_q != IDLE);

    // NOTE: every output and state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        DBG_output_sel = '0;
        DBG_load       = 1'b0;
        DBG_pc_val_out = '0;
        DBG_word_valid = 1'b0;
        DBG_word_sel   = '0;
        DBG_word_data  = '0;
        DBG_done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (DBG_start) state_d = DBG_load_req ? LOAD : SCAN_ENTRY;
            end
            LOAD: begin
                DBG_load       = 1'b1;
                DBG_pc_val_out = pc_q;
                state_d        = SCAN_ENTRY;
            end
`ifdef DBG_FREEZE_EN
            PREP: begin
                // View 7 exposes the PC on leds[15:8]; it is captured as the frozen PC.
                DBG_output_sel = 8'd7;
                state_d        = CAPTURE;
            end
`endif
            CAPTURE: begin
                DBG_output_sel = {5'b0, sel_q};
`ifdef DBG_FREEZE_EN
                DBG_load       = 1'b1;
                DBG_pc_val_out = frozen_q;
`endif
                if (settle_done && sel_q == SEL_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                // idx_q == WORD_END marks the one-cycle done slot after the last transfer.
                if (idx_q == WORD_END) begin
                    DBG_done = 1'b1;
                    state_d  = IDLE;
                end else begin
                    DBG_word_valid = 1'b1;
                    DBG_word_sel   = idx_q[2:0];
                    DBG_word_data  = snap_q[idx_q[2:0]];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            pc_q     <= '0;
`ifdef DBG_FREEZE_EN
            frozen_q <= '0;
`endif
            // NOTE: the snapshot buffer is reset so a discarded partial scan can never leak out later.
            for (int i = 0; i < NUM_SEL; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && DBG_start) pc_q <= DBG_pc_val;
`ifdef DBG_FREEZE_EN
            if (state_q == PREP) frozen_q <= DBG_leds_in[15:8];
`endif
            if (state_q == CAPTURE) begin
                if (settle_done) begin
                    snap_q[sel_q] <= DBG_leds_in;
                    settle_q      <= '0;
                    sel_q         <= sel_q + 3'd1;
                end else begin
                    settle_q <= settle_q + SW'(1);
                end
            end else begin
                sel_q    <= '0;
                settle_q <= '0;
            end
            if (state_q == DRAIN) begin
                if (idx_q != WORD_END && DBG_word_ready) idx_q <= idx_q + 4'd1;
            end else begin
                idx_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sys_debug_scanner.sv
// Directed bench for sys_debug_scanner; E0 is the edge that samples DBG_start, "after En" is #1 past edge n.
module tb_sys_debug_scanner;
    localparam int LED_W = 27;
`ifdef DBG_FREEZE_EN
    localparam int FRZ = 1;
`else
    localparam int FRZ = 0;
`endif

    logic             SYS_clk = 1'b0;
    logic             SYS_reset = 1'b1;
    logic             DBG_start = 1'b0;
    logic             DBG_load_req = 1'b0;
    logic [7:0]       DBG_pc_val = 8'h00;
    logic [7:0]       DBG_output_sel;
    logic             DBG_load;
    logic [7:0]       DBG_pc_val_out;
    logic [LED_W-1:0] DBG_leds_in;
    logic             DBG_busy;
    logic             DBG_word_valid;
    logic             DBG_word_ready = 1'b1;
    logic [2:0]       DBG_word_sel;
    logic [LED_W-1:0] DBG_word_data;
    logic             DBG_done;

    logic [LED_W-1:0] led_base = 27'h100000;

    sys_debug_scanner dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .DBG_start(DBG_start),
        .DBG_load_req(DBG_load_req), .DBG_pc_val(DBG_pc_val), .DBG_output_sel(DBG_output_sel),
        .DBG_load(DBG_load), .DBG_pc_val_out(DBG_pc_val_out), .DBG_leds_in(DBG_leds_in),
        .DBG_busy(DBG_busy), .DBG_word_valid(DBG_word_valid), .DBG_word_ready(DBG_word_ready),
        .DBG_word_sel(DBG_word_sel), .DBG_word_data(DBG_word_data), .DBG_done(DBG_done)
    );

    // Core model: each view shows a distinct word derived from the selected view.
    assign DBG_leds_in = led_base | (LED_W'(DBG_output_sel) << 4);

    always #5 SYS_clk = ~SYS_clk;

    int n_vec = 0;
    int n_err = 0;

    // Recorder results filled in by run_obs.
    int cur, first_valid, done_cnt, done_at, load_cnt, load_first, load_bad;
    int held_bad, stall_seen, busy_after, reset_at;
    logic [2:0]       x_sel  [$];
    logic [LED_W-1:0] x_data [$];
    int               x_edge [$];
    logic [23:0]      rst_outs;
    logic [LED_W-1:0] rst_data;
    // Recorder controls.
    int stall_word, stall_len, repulse_at, reset_word;
    bit start_at_done;
    logic [7:0] exp_load_pc;

    task automatic clear_rec();
        first_valid = -1; done_cnt = 0; done_at = -1; load_cnt = 0; load_first = -1;
        load_bad = 0; held_bad = 0; stall_seen = 0; busy_after = 0; reset_at = -1;
        x_sel.delete(); x_data.delete(); x_edge.delete();
        rst_outs = '1; rst_data = '1;
        stall_word = -1; stall_len = 0; repulse_at = -1; reset_word = -1;
        start_at_done = 1'b0; exp_load_pc = 8'h00;
    endtask

    task automatic start_scan(input logic lr, input logic [7:0] pc);
        @(negedge SYS_clk);
        DBG_start = 1'b1; DBG_load_req = lr; DBG_pc_val = pc;
        @(posedge SYS_clk); #1;
        DBG_start = 1'b0; DBG_load_req = 1'b0; DBG_pc_val = 8'hFF;
        cur = 0;
    endtask

    // Observes outputs after each edge, drives ready/start, logs transfers at the edge they occur.
    task automatic run_obs(input int ncyc);
        bit stalled_prev = 1'b0;
        bit reset_done = 1'b0;
        int stall_left = stall_len;
        logic [2:0] ps = '0;
        logic [LED_W-1:0] pd = '0;
        for (int c = 0; c < ncyc; c++) begin
            DBG_start = (cur == repulse_at) || (start_at_done && DBG_done);
            if (DBG_word_valid && first_valid < 0) first_valid = cur;
            if (DBG_load) begin
                load_cnt++;
                if (load_first < 0) load_first = cur;
                if (DBG_pc_val_out !== exp_load_pc) load_bad++;
            end
            if (DBG_done) begin done_cnt++; done_at = cur; end
            if (done_cnt > 0 && done_at < cur && DBG_busy) busy_after++;
            if (stalled_prev && DBG_word_valid && (DBG_word_sel !== ps || DBG_word_data !== pd)) held_bad++;
            if (reset_word >= 0 && !reset_done && DBG_word_valid && DBG_word_sel == 3'(reset_word)) begin
                reset_done = 1'b1;
                reset_at = cur;
                #3 SYS_reset = 1'b1;
                #1 rst_outs = {DBG_busy, DBG_word_valid, DBG_done, DBG_load, DBG_output_sel,
                               DBG_pc_val_out, 1'b0, DBG_word_sel};
                rst_data = DBG_word_data;
                #2 SYS_reset = 1'b0;
                stalled_prev = 1'b0;
            end else begin
                DBG_word_ready = 1'b1;
                if (DBG_word_valid && DBG_word_sel == 3'(stall_word) && stall_left > 0) begin
                    DBG_word_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end
                stalled_prev = DBG_word_valid && !DBG_word_ready;
                ps = DBG_word_sel;
                pd = DBG_word_data;
                if (DBG_word_valid && DBG_word_ready) begin
                    x_sel.push_back(DBG_word_sel);
                    x_data.push_back(DBG_word_data);
                    x_edge.push_back(cur + 1);
                end
            end
            @(posedge SYS_clk); #1;
            cur++;
        end
        DBG_start = 1'b0;
        DBG_word_ready = 1'b1;
    endtask

    task automatic check_words(input string tag, input int first_edge, input int gap_after2);
        n_vec++;
        if (x_sel.size() != 8) begin
            n_err++;
            $display("FAIL %s word_count: got %0d expected 8", tag, x_sel.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (x_sel[i] !== 3'(i) || x_data[i] !== (led_base | (LED_W'(i) << 4))
                    || x_edge[i] !== first_edge + i + ((i >= 2) ? gap_after2 : 0)) begin
                    n_err++;
                    $display("FAIL %s word%0d: got sel=%0d data=%h edge=%0d expected sel=%0d data=%h edge=%0d",
                             tag, i, x_sel[i], x_data[i], x_edge[i], i, led_base | (LED_W'(i) << 4),
                             first_edge + i + ((i >= 2) ? gap_after2 : 0));
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({DBG_busy, DBG_word_valid, DBG_done, DBG_load, DBG_output_sel, DBG_pc_val_out, DBG_word_sel} !== '0
            || DBG_word_data !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b valid=%b done=%b load=%b sel=%h pc=%h wsel=%0d data=%h expected all 0",
                     DBG_busy, DBG_word_valid, DBG_done, DBG_load, DBG_output_sel, DBG_pc_val_out,
                     DBG_word_sel, DBG_word_data);
        end
        @(negedge SYS_clk); SYS_reset = 1'b0;
        start_scan(1'b1, 8'h5A);
        n_vec++;
        if (DBG_load !== 1'b1 || DBG_pc_val_out !== 8'h5A) begin
            n_err++;
            $display("FAIL load_cycle: got load=%b pc=%h expected load=1 pc=5a", DBG_load, DBG_pc_val_out);
        end
        #3 SYS_reset = 1'b1;
        #1;
        n_vec++;
        if ({DBG_busy, DBG_word_valid, DBG_done, DBG_load, DBG_output_sel, DBG_pc_val_out} !== '0) begin
            n_err++;
            $display("FAIL async_reset_mid_load: got busy=%b load=%b pc=%h sel=%h expected all 0",
                     DBG_busy, DBG_load, DBG_pc_val_out, DBG_output_sel);
        end
        #2 SYS_reset = 1'b0;
        repeat (2) @(posedge SYS_clk);
        #1;
        n_vec++;
        if (DBG_busy !== 1'b0 || DBG_load !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b load=%b expected 0 0", DBG_busy, DBG_load);
        end
    endtask

    task automatic test_basic_scan();
        clear_rec();
        led_base = 27'h100000;
        start_scan(1'b0, 8'h00);
        run_obs(30);
        check_words("basic", 17 + FRZ, 0);
        n_vec++;
        if (first_valid !== 16 + FRZ || done_cnt !== 1 || done_at !== 24 + FRZ || busy_after !== 0) begin
            n_err++;
            $display("FAIL basic_timing: got valid_after=E%0d done_cnt=%0d done_after=E%0d busy_after=%0d expected E%0d 1 E%0d 0",
                     first_valid, done_cnt, done_at, busy_after, 16 + FRZ, 24 + FRZ);
        end
`ifndef DBG_FREEZE_EN
        n_vec++;
        if (load_cnt !== 0) begin
            n_err++;
            $display("FAIL basic_no_load: got %0d load cycles expected 0", load_cnt);
        end
`endif
    endtask

    task automatic test_pc_load();
        clear_rec();
        exp_load_pc = 8'h20;
        start_scan(1'b1, 8'h20);
        run_obs(32);
        check_words("load", 18 + FRZ, 0);
        n_vec++;
        if (first_valid !== 17 + FRZ || done_at !== 25 + FRZ || done_cnt !== 1) begin
            n_err++;
            $display("FAIL load_timing: got valid_after=E%0d done_after=E%0d done_cnt=%0d expected E%0d E%0d 1",
                     first_valid, done_at, done_cnt, 17 + FRZ, 25 + FRZ);
        end
`ifndef DBG_FREEZE_EN
        n_vec++;
        if (load_cnt !== 1 || load_first !== 0 || load_bad !== 0) begin
            n_err++;
            $display("FAIL load_pulse: got cycles=%0d first_after=E%0d bad_pc=%0d expected 1 E0 0",
                     load_cnt, load_first, load_bad);
        end
`endif
    endtask

    task automatic test_backpressure();
        clear_rec();
        stall_word = 2;
        stall_len = 3;
        start_scan(1'b0, 8'h00);
        run_obs(34);
        check_words("stall", 17 + FRZ, 3);
        n_vec++;
        if (stall_seen !== 3 || held_bad !== 0 || done_cnt !== 1 || done_at !== 27 + FRZ) begin
            n_err++;
            $display("FAIL stall_hold: got stalls=%0d unstable=%0d done_cnt=%0d done_after=E%0d expected 3 0 1 E%0d",
                     stall_seen, held_bad, done_cnt, done_at, 27 + FRZ);
        end
    endtask

    task automatic test_restart_and_reset();
        clear_rec();
        repulse_at = 5;
        reset_word = 4;
        start_scan(1'b0, 8'h00);
        run_obs(40);
        n_vec++;
        if (x_sel.size() !== 4 || reset_at !== 20 + FRZ) begin
            n_err++;
            $display("FAIL repulse_reset: got transfers=%0d reset_after=E%0d expected 4 E%0d",
                     x_sel.size(), reset_at, 20 + FRZ);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (x_sel[i] !== 3'(i) || x_edge[i] !== 17 + FRZ + i) begin
                    n_err++;
                    $display("FAIL repulse_word%0d: got sel=%0d edge=%0d expected sel=%0d edge=%0d",
                             i, x_sel[i], x_edge[i], i, 17 + FRZ + i);
                end
            end
        end
        n_vec++;
        if (rst_outs !== '0 || rst_data !== '0) begin
            n_err++;
            $display("FAIL reset_mid_drain: got outs=%h data=%h expected 0 0", rst_outs, rst_data);
        end
        n_vec++;
        if (done_cnt !== 0 || DBG_busy !== 1'b0 || DBG_word_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got done_cnt=%0d busy=%b valid=%b expected 0 0 0",
                     done_cnt, DBG_busy, DBG_word_valid);
        end
    endtask

    task automatic test_start_at_done();
        clear_rec();
        start_at_done = 1'b1;
        start_scan(1'b0, 8'h00);
        run_obs(30);
        n_vec++;
        if (done_cnt !== 1 || busy_after !== 0 || DBG_busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_at_done: got done_cnt=%0d busy_after=%0d busy=%b expected 1 0 0",
                     done_cnt, busy_after, DBG_busy);
        end
    endtask

`ifdef DBG_FREEZE_EN
    task automatic test_freeze();
        clear_rec();
        led_base = 27'h101400;
        exp_load_pc = 8'h14;
        start_scan(1'b0, 8'h00);
        run_obs(32);
        check_words("freeze", 18, 0);
        n_vec++;
        if (load_cnt !== 16 || load_first !== 1 || load_bad !== 0 || first_valid !== 17) begin
            n_err++;
            $display("FAIL freeze_load: got cycles=%0d first_after=E%0d bad_pc=%0d valid_after=E%0d expected 16 E1 0 E17",
                     load_cnt, load_first, load_bad, first_valid);
        end
        led_base = 27'h100000;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_scan();
        test_pc_load();
        test_backpressure();
        test_restart_and_reset();
        test_start_at_done();
`ifdef DBG_FREEZE_EN
        test_freeze();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
